serial_to_parallel_align: RTL and testbench

//   Receive-side partner of the parallel-to-serial/IDLE transmitter. Deserialises the 1-bit lane
//   (MSB first) into bytes and finds the byte boundary by detecting COM symbols (0xBC).

---
 rtl/serial_to_parallel_align.sv | 133 +++++++++++++
 tb/tb_serial_to_parallel_align.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_align.sv
// rtl/serial_to_parallel_align.sv - bit-serial deserialiser with COM-symbol byte alignment
// Optional build macro S2P_IDLE_FILTER_EN: drop IDL_BYTE symbols from valid_out while ACTIVE.
module serial_to_parallel_align #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] COM_BYTE = 8'hBC,
  parameter logic [WIDTH-1:0] IDL_BYTE = 8'h7C,
  parameter int              COM_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active_out,
  output logic [2:0]       com_cnt
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [2:0] COM_TARGET = 3'(COM_COUNT);

`ifdef S2P_IDLE_FILTER_EN
  localparam bit IDLE_FILTER = 1'b1;
`else
  localparam bit IDLE_FILTER = 1'b0;
`endif

  typedef enum logic [1:0] {SEARCH, LOCK, ACTIVE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sr, sr_next;
  logic [CW-1:0]    bit_cnt, bit_cnt_d;
  logic [WIDTH-1:0] data_d;
  logic             valid_d, active_d;
  logic [2:0]       com_cnt_d, com_cnt_inc;
  logic             boundary, is_com, idle_drop;

  assign sr_next     = {sr[WIDTH-2:0], serial_in};
  assign boundary    = (bit_cnt == LAST_BIT);
  assign is_com      = (sr_next == COM_BYTE);
  assign idle_drop   = IDLE_FILTER && (sr_next == IDL_BYTE);
  assign com_cnt_inc = com_cnt + 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEARCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SEARCH: begin
        if (is_com) begin
          state_next = (COM_COUNT == 1) ? ACTIVE : LOCK;
        end
      end
      LOCK: begin
        // A non-COM at the expected boundary means the lock was false; hunt again.
        if (boundary) begin
          if (!is_com) begin
            state_next = SEARCH;
          end else if (com_cnt_inc == COM_TARGET) begin
            state_next = ACTIVE;
          end
        end
      end
      ACTIVE:  state_next = ACTIVE;
      default: state_next = SEARCH;
    endcase
  end

  always_comb begin
    bit_cnt_d = boundary ? '0 : bit_cnt + CW'(1);
    com_cnt_d = com_cnt;
    data_d    = data_out;
    valid_d   = 1'b0;
    active_d  = active_out;
    case (state)
      SEARCH: begin
        bit_cnt_d = '0;
        if (is_com) begin
          com_cnt_d = 3'd1;
          if (COM_COUNT == 1) begin
            active_d = 1'b1;
          end
        end
      end
      LOCK: begin
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_cnt_inc;
            if (com_cnt_inc == COM_TARGET) begin
              active_d = 1'b1;
            end
          end else begin
            com_cnt_d = 3'd0;
          end
        end
      end
      ACTIVE: begin
        if (boundary) begin
          data_d  = sr_next;
          valid_d = !is_com && !idle_drop;
        end
      end
      default: begin
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr         <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      active_out <= 1'b0;
      com_cnt    <= 3'd0;
    end else begin
      sr         <= sr_next;
      bit_cnt    <= bit_cnt_d;
      data_out   <= data_d;
      valid_out  <= valid_d;
      active_out <= active_d;
      com_cnt    <= com_cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_align.sv
// tb/tb_serial_to_parallel_align.sv - self-checking bench for serial_to_parallel_align
// Honours S2P_IDLE_FILTER_EN for the idle-symbol expectation.
module tb_serial_to_parallel_align;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] IDL = 8'h7C;
`ifdef S2P_IDLE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active_out;
  logic [2:0] com_cnt;

  serial_to_parallel_align dut (
    .clk(clk), .reset(reset), .serial_in(serial_in),
    .data_out(data_out), .valid_out(valid_out),
    .active_out(active_out), .com_cnt(com_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: bit index arithmetic on the received stream.
  int         m_mode = 0;   // 0 hunting, 1 counting COMs, 2 active
  int         m_cnt = 0;
  int         m_idx = 0;
  int         m_anchor = 0;
  int         m_win = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_active = 1'b0;

  typedef struct {
    bit         rst;
    int         pre;
    logic [7:0] sym;
    bit         act;
    bit         val;
    logic [7:0] data;
    int         cnt;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit b);
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_idx = 0; m_anchor = 0; m_win = 0;
      m_data = 8'h00; m_valid = 1'b0; m_active = 1'b0;
      return;
    end
    m_idx++;
    m_win = (m_win * 2 + int'(b)) % 256;
    m_valid = 1'b0;
    if (m_mode == 0) begin
      if (m_win == int'(COM)) begin
        m_cnt = 1;
        m_anchor = m_idx;
        m_mode = 1;
      end
    end else if ((m_idx - m_anchor) % 8 == 0) begin
      if (m_mode == 1) begin
        if (m_win == int'(COM)) begin
          m_cnt++;
          if (m_cnt == 4) begin
            m_mode = 2;
            m_active = 1'b1;
          end
        end else begin
          m_mode = 0;
          m_cnt = 0;
        end
      end else begin
        m_data = 8'(m_win);
        m_valid = (m_win != int'(COM)) && !(FILT && m_win == int'(IDL));
      end
    end
  endtask

  task automatic step(input bit rst, input bit b);
    @(negedge clk);
    reset = rst;
    serial_in = b;
    @(posedge clk);
    model_step(rst, b);
    #1;
    chk("cyc_data", int'(data_out), int'(m_data));
    chk("cyc_valid", int'(valid_out), int'(m_valid));
    chk("cyc_active", int'(active_out), int'(m_active));
    chk("cyc_com_cnt", int'(com_cnt), m_cnt);
  endtask

  task automatic send_sym(input logic [7:0] s);
    for (int i = 7; i >= 0; i--) step(1'b0, s[i]);
  endtask

  task automatic push(input bit rst, input int pre, input logic [7:0] sym,
                      input bit act, input bit val, input logic [7:0] data, input int cnt);
    vec_t v;
    v.rst = rst; v.pre = pre; v.sym = sym; v.act = act;
    v.val = val; v.data = data; v.cnt = cnt;
    tv.push_back(v);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, int'(data_out), 0);
    chk({tag, "_valid"}, int'(valid_out), 0);
    chk({tag, "_active"}, int'(active_out), 0);
    chk({tag, "_com_cnt"}, int'(com_cnt), 0);
  endtask

  initial begin
    // Four COMs then two data bytes
    push(1, 0, COM,   0, 0, 8'h00, 1);
    push(0, 0, COM,   0, 0, 8'h00, 2);
    push(0, 0, COM,   0, 0, 8'h00, 3);
    push(0, 0, COM,   1, 0, 8'h00, 4);
    push(0, 0, 8'h11, 1, 1, 8'h11, 4);
    push(0, 0, 8'h22, 1, 1, 8'h22, 4);
    // Three junk bits ahead of the COMs
    push(1, 3, COM,   0, 0, 8'h00, 1);
    push(0, 0, COM,   0, 0, 8'h00, 2);
    push(0, 0, COM,   0, 0, 8'h00, 3);
    push(0, 0, COM,   1, 0, 8'h00, 4);
    push(0, 0, 8'h11, 1, 1, 8'h11, 4);
    push(0, 0, 8'h22, 1, 1, 8'h22, 4);
    // Broken COM run forces a re-hunt
    push(1, 0, COM,   0, 0, 8'h00, 1);
    push(0, 0, COM,   0, 0, 8'h00, 2);
    push(0, 0, 8'h55, 0, 0, 8'h00, 0);
    push(0, 0, COM,   0, 0, 8'h00, 1);
    push(0, 0, COM,   0, 0, 8'h00, 2);
    push(0, 0, COM,   0, 0, 8'h00, 3);
    push(0, 0, COM,   1, 0, 8'h00, 4);
    // COM / idle / data while active
    push(0, 0, COM,   1, 0, COM,   4);
    push(0, 0, IDL,   1, !FILT, IDL, 4);
    push(0, 0, 8'hA5, 1, 1, 8'hA5, 4);

    for (int i = 0; i < 3; i++) step(1'b1, 1'(i % 2));
    check_zero("reset3");

    foreach (tv[i]) begin
      if (tv[i].rst) step(1'b1, 1'b0);
      for (int k = 0; k < tv[i].pre; k++) step(1'b0, 1'(k % 2));
      send_sym(tv[i].sym);
      chk($sformatf("tv%0d_active", i), int'(active_out), int'(tv[i].act));
      chk($sformatf("tv%0d_valid", i), int'(valid_out), int'(tv[i].val));
      chk($sformatf("tv%0d_data", i), int'(data_out), int'(tv[i].data));
      chk($sformatf("tv%0d_com_cnt", i), int'(com_cnt), tv[i].cnt);
    end

    // Data pulse lasts one cycle only
    send_sym(8'h3C);
    step(1'b0, 1'b0);
    chk("pulse_width", int'(valid_out), 0);
    chk("pulse_hold_data", int'(data_out), 8'h3C);

    // Mid-symbol reset while active, then full re-lock
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check_zero("midreset");
    for (int i = 0; i < 3; i++) send_sym(COM);
    chk("relock3_active", int'(active_out), 0);
    chk("relock3_cnt", int'(com_cnt), 3);
    send_sym(COM);
    chk("relock4_active", int'(active_out), 1);
    send_sym(8'h9E);
    chk("relock_data", int'(data_out), 8'h9E);
    chk("relock_valid", int'(valid_out), 1);

    // Random symbol streams with junk bits and occasional resets
    step(1'b1, 1'b0);
    for (int r = 0; r < 250; r++) begin
      int sel;
      if ($urandom_range(39) == 0) step(1'b1, 1'($urandom_range(1)));
      if ($urandom_range(7) == 0) begin
        int n;
        n = $urandom_range(7);
        for (int k = 0; k < n; k++) step(1'b0, 1'($urandom_range(1)));
      end
      sel = $urandom_range(9);
      if (sel < 5)       send_sym(COM);
      else if (sel == 5) send_sym(IDL);
      else               send_sym(8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
